// File: rtl/uart_rx_if.sv
// Serial-line and received-word signals of the UART receiver.
// The bench drives the master side; uart_rx consumes the slave side.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversamples RX_IN, majority-votes at mid-bit, deserialises LSB first,
// and reports a good word, a parity error or a stop error with one-cycle pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input logic       CLK,
    input logic       RST,
    uart_rx_if.slave  bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  rx_s;
    logic                  armed_q;
    logic [5:0]            p_q;
    logic                  par_en_q, par_typ_q;
    logic [5:0]            edge_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [2:0]            smp_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bad_q;
    logic [DATA_WIDTH-1:0] pdata_q;
    logic                  dv_q, perr_q, serr_q;

    logic [5:0] half;
    logic       mid, last, maj, start_det;

    assign rx_s = sync_q[1];
    assign half = p_q >> 1;
    assign mid  = (edge_q == half + 6'd2);
    assign last = (edge_q == p_q - 6'd1);
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    assign bus.P_DATA     = pdata_q;
    assign bus.DATA_VALID = dv_q;
    assign bus.PAR_ERR    = perr_q;
    assign bus.STP_ERR    = serr_q;

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !rx_s) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (mid && maj)
                    state_d = IDLE;
                else if (last)
                    state_d = DATA;
            end
            DATA: begin
                if (last && bit_cnt_q == BW'(DATA_WIDTH - 1))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (last)
                    state_d = STOP;
            end
            STOP: begin
                if (mid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            armed_q   <= 1'b0;
            p_q       <= 6'd8;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            edge_q    <= '0;
            bit_cnt_q <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], bus.RX_IN};
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;

            if (state_q == IDLE) begin
                // The detection cycle itself is edge 0 of the start bit.
                edge_q <= start_det ? 6'd1 : 6'd0;
                if (start_det) begin
                    armed_q   <= 1'b0;
                    par_en_q  <= bus.PAR_EN;
                    par_typ_q <= bus.PAR_TYP;
                    par_bad_q <= 1'b0;
                    bit_cnt_q <= '0;
                    case (bus.PRESCALE)
                        6'd16:   p_q <= 6'd16;
                        6'd32:   p_q <= 6'd32;
                        default: p_q <= 6'd8;
                    endcase
                end else if (rx_s) begin
                    armed_q <= 1'b1;
                end
            end else begin
                edge_q <= (last || state_d == IDLE) ? 6'd0 : edge_q + 6'd1;

                if (edge_q == half - 6'd1) smp_q[0] <= rx_s;
                if (edge_q == half)        smp_q[1] <= rx_s;
                if (edge_q == half + 6'd1) smp_q[2] <= rx_s;

                if (state_q == DATA && mid)
                    shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
                if (state_q == DATA && last)
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                if (state_q == PARITY && mid)
                    par_bad_q <= maj ^ (^shift_q) ^ par_typ_q;

                // A high stop sample re-arms IDLE so a start edge can follow immediately.
                if (state_q == STOP && mid) begin
                    armed_q <= maj;
                    serr_q  <= ~maj;
                    perr_q  <= par_bad_q;
                    if (maj && !par_bad_q) begin
                        dv_q    <= 1'b1;
                        pdata_q <= shift_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected pulses are queued
// with their arrival cycle and checked by a monitor when the receiver reports.
module tb_uart_rx;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   frames = 0;

    typedef struct {
        logic [7:0] pdata;
        logic       dv;
        logic       perr;
        logic       serr;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge; returns in the same position.
    task automatic send(input logic [7:0] d, input int p, input bit pe, input bit pt,
                        input bit bad_par, input bit stop_bit);
        exp_t e;
        logic par_bit;
        int   nb;
        par_bit = (^d) ^ pt ^ bad_par;
        nb      = 1 + 8 + (pe ? 1 : 0);
        bus.PRESCALE = 6'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        bus.RX_IN    = 1'b0;
        e.perr  = pe && bad_par;
        e.serr  = !stop_bit;
        e.dv    = !e.perr && !e.serr;
        if (e.dv) last_good = d;
        e.pdata = last_good;
        e.cyc   = cyc + 2 + nb * p + p / 2 + 3;
        q.push_back(e);
        frames++;
        repeat (p) @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.RX_IN = d[i];
            repeat (p) @(posedge CLK);
            #1;
        end
        if (pe) begin
            bus.RX_IN = par_bit;
            repeat (p) @(posedge CLK);
            #1;
        end
        bus.RX_IN = stop_bit;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && q.size() != 0; i++) @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (!RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            exp_t e;
            pulses++;
            chk("pulse_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("data_valid", 32'(bus.DATA_VALID), 32'(e.dv));
                chk("par_err",    32'(bus.PAR_ERR),    32'(e.perr));
                chk("stp_err",    32'(bus.STP_ERR),    32'(e.serr));
                chk("p_data",     32'(bus.P_DATA),     32'(e.pdata));
                chk("pulse_cycle", 32'(cyc),           32'(e.cyc));
            end
        end
    end

    initial begin
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_data_valid", 32'(bus.DATA_VALID), 32'd0);
        chk("rst_par_err",    32'(bus.PAR_ERR),    32'd0);
        chk("rst_stp_err",    32'(bus.STP_ERR),    32'd0);
        chk("rst_p_data",     32'(bus.P_DATA),     32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;

        // Good frame with even parity: pulse expected at t0+89.
        send(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        drain(200);

        // Odd parity with the parity bit flipped.
        send(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1);
        drain(200);

        // Stop bit low, then the line stays low as a break.
        send(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (50) @(posedge CLK);
        #1;
        bus.RX_IN = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        drain(10);
        send(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(200);

        // Two-cycle start glitch must not produce any pulse.
        bus.RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        bus.RX_IN = 1'b1;
        repeat (30) @(posedge CLK);
        #1;
        chk("glitch_no_pulse", 32'(pulses), 32'd4);
        send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(200);

        // Back-to-back frames at P=32.
        send(8'h12, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h34, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(400);

        // Reset during data bit 3.
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (38) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst_data_valid", 32'(bus.DATA_VALID), 32'd0);
        chk("midrst_par_err",    32'(bus.PAR_ERR),    32'd0);
        chk("midrst_stp_err",    32'(bus.STP_ERR),    32'd0);
        chk("midrst_p_data",     32'(bus.P_DATA),     32'd0);
        last_good = 8'h00;
        bus.RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        send(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(200);

        repeat (20) @(posedge CLK);
        #1;
        chk("pulse_total", 32'(pulses), 32'(frames));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the UART link. Deserializes an asynchronous serial line (RX_IN) into parallel words.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit.
- Oversamples each bit PRESCALE times and takes a majority vote at mid-bit.
- Drives a one-cycle DATA_VALID pulse toward the system-side synchronizer/FIFO, and reports parity and stop errors.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- CLK  input  1  oversampling clock (PRESCALE x baud rate).
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line; idles high; asynchronous to CLK.
- PRESCALE  input  6  oversampling ratio; legal values are 8, 16 and 32.
- PAR_EN  input  1  1 = a parity bit is present in the frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- DATA_VALID  output  1  one-cycle pulse when a good frame is received.
- PAR_ERR  output  1  one-cycle pulse when a parity mismatch is detected.
- STP_ERR  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- **Reset.** Clock is CLK; reset is asynchronous, active-high, named RST.
  - While RST is high, all outputs are 0, P_DATA is 0, the FSM is in IDLE, all counters are 0, and the armed flag is 0.
  - Asserting RST mid-frame aborts the frame immediately and produces no output pulse.
- **Input synchronizer.**
  - RX_IN passes through a 2-flop synchronizer; the result is rx_s.
  - All timing below refers to rx_s, which lags RX_IN by 2 CLK cycles.
  - The synchronizer resets to 1.
- **Configuration latch.**
  - PRESCALE, PAR_EN and PAR_TYP are latched on start detection and held for the whole frame.
  - A latched PRESCALE value other than 16 or 32 is treated as 8.
- **Counters.**
  - edge_cnt runs 0..P-1 within each bit, where P is the latched prescale; it wraps to 0 and advances bit_cnt.
  - The first cycle in which rx_s is low counts as edge_cnt=0 of the start bit.
- **Mid-bit sampling.**
  - rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The majority of the three samples is the bit value, valid from edge_cnt = P/2+2.
- **FSM states.** IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - armed is set by any cycle with rx_s=1.
    - If armed and rx_s=0, go to START with edge_cnt=1 and clear armed.
    - Result: a line held low after reset or after a break never starts a frame.
  - START: at edge_cnt = P/2+2, if the majority is 1 (glitch), return to IDLE with no pulses. Otherwise, at edge_cnt = P-1, go to DATA.
  - DATA:
    - Each majority bit shifts in LSB first.
    - After DATA_WIDTH bits, go to PARITY if PAR_EN, else to STOP.
  - PARITY:
    - Expected parity bit = XOR of the data bits, inverted if PAR_TYP=1.
    - A mismatch is recorded.
    - At edge_cnt = P-1, go to STOP.
  - STOP:
    - At edge_cnt = P/2+2, evaluate the stop bit; a majority of 0 is a stop error.
    - Then return to IDLE in the next cycle. Returning at mid-stop allows back-to-back frames.
- **Output pulses** (registered, high for exactly one cycle, in the cycle after the STOP evaluation):
  - Parity mismatch: PAR_ERR=1.
  - Stop sample low: STP_ERR=1.
  - Both errors can pulse together.
  - No error: DATA_VALID=1 and P_DATA updates in the same cycle.
  - On any error, P_DATA keeps its previous value and DATA_VALID stays 0.
- **Latency.** With RX_IN falling at cycle t0, the output pulse occurs at t0 + 2 + NB*P + P/2 + 3, where NB = 1 + DATA_WIDTH + PAR_EN.
  - P=8, parity on: t0+89.
  - P=8, parity off: t0+81.
- **Simultaneous events.** A start edge arriving in the same cycle as the output pulse is accepted, provided the stop bit re-armed IDLE.

Test Plan:
- **Good frame, parity on.** P=8, PAR_EN=1, PAR_TYP=0; send 0xA5 (data bits 1,0,1,0,0,1,0,1, parity 0, stop 1), RX_IN falling at t0 -> DATA_VALID=1 at t0+89, P_DATA=0xA5, PAR_ERR=0, STP_ERR=0.
- **Parity error.** P=16, PAR_EN=1, PAR_TYP=1; send 0x3C with parity bit 0 (correct value is 1) -> PAR_ERR pulses, DATA_VALID=0, P_DATA unchanged.
- **Stop error, then break.** P=8, PAR_EN=0; send 0x55 with stop bit 0, then hold RX_IN low for 50 cycles -> STP_ERR pulse at t0+81, no new frame is started. After RX_IN returns high, frame 0x0F is received correctly.
- **Start glitch.** RX_IN low for 2 cycles, then high (P=8) -> no pulses, FSM back in IDLE. A following 0x81 frame is received correctly.
- **Back-to-back frames.** P=32, parity off; frames 0x12 and 0x34 with the second start immediately after the stop bit -> two DATA_VALID pulses with values 0x12 then 0x34.
- **Reset mid-frame.** Assert RST during data bit 3 of a frame -> outputs are 0 immediately. After release, with RX_IN high, frame 0xFF is received correctly and no stale pulse appears.
